// File: rtl/adc_spi_slave.sv
// SPI responder standing in for the hydrophone ADC: answers the channel-read command with a
// 64-bit A/B/C/D sample word, accepts 16-bit register writes and drives the active-low EOC strobe.
module adc_spi_slave #(
   parameter logic [7:0] READ_CMD  = 8'h1A,
   parameter int         DATA_BITS = 64
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [DATA_BITS-1:0] SAMPLE,
   input  logic                 SAMPLE_VALID,
   input  logic                 SCLK,
   input  logic                 CS,
   input  logic                 MOSI,
   output logic                 MISO,
   output logic                 EOC,
   output logic [7:0]           REG_ADDR,
   output logic [7:0]           REG_DATA,
   output logic                 REG_WE,
   output logic                 OVERRUN,
   output logic                 FRAME_ERR
);

   localparam int CW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] BYTE_LAST = CW'(7);
   localparam logic [CW-1:0] WORD_LAST = CW'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, CMD, READ, WDATA, DRAIN} state_t;

   state_t               state;
   logic [2:0]           sclk_sync;
   logic [2:0]           cs_sync;
   logic [1:0]           mosi_sync;
   logic [CW-1:0]        bit_cnt;
   logic [6:0]           rx_shift;
   logic [7:0]           addr_q;
   logic [DATA_BITS-2:0] tx_shift;
   logic [DATA_BITS-1:0] hold;
   logic                 pending;

   logic       sclk_rise;
   logic       cs_fall;
   logic       cs_rise;
   logic [7:0] rx_byte;
   logic       read_load;

   // Stage [0]/[1] form the two-flop synchronizer; stage [2] is the previous value for edge detection.
   // CS resets high so leaving reset never fakes a frame start.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sclk_sync <= 3'b000;
         cs_sync   <= 3'b111;
         mosi_sync <= 2'b00;
      end else begin
         // NOTE: every flop updates with <= so all stages shift from the same pre-edge values.
         sclk_sync <= {sclk_sync[1:0], SCLK};
         cs_sync   <= {cs_sync[1:0], CS};
         mosi_sync <= {mosi_sync[0], MOSI};
      end
   end

   assign sclk_rise = ~cs_sync[1] & sclk_sync[1] & ~sclk_sync[2];
   assign cs_fall   = ~cs_sync[1] & cs_sync[2];
   assign cs_rise   = cs_sync[1] & ~cs_sync[2];
   assign rx_byte   = {rx_shift, mosi_sync[1]};
   assign read_load = (state == CMD) && sclk_rise && (bit_cnt == BYTE_LAST) && (rx_byte == READ_CMD);

   assign EOC = ~pending;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         rx_shift  <= '0;
         addr_q    <= '0;
         // NOTE: the sample holding and shift registers are reset too, so a read straight after
         // reset returns zero rather than stale data.
         tx_shift  <= '0;
         hold      <= '0;
         pending   <= 1'b0;
         MISO      <= 1'b0;
         REG_ADDR  <= '0;
         REG_DATA  <= '0;
         REG_WE    <= 1'b0;
         OVERRUN   <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         REG_WE    <= 1'b0;
         OVERRUN   <= 1'b0;
         FRAME_ERR <= 1'b0;

         // A sample landing in the same cycle as a read load is the next pending sample, not an overrun.
         if (SAMPLE_VALID) begin
            hold    <= SAMPLE;
            pending <= 1'b1;
            if (pending && !read_load) OVERRUN <= 1'b1;
         end else if (read_load) begin
            pending <= 1'b0;
         end

         case (state)
            IDLE: begin
               MISO <= 1'b0;
               if (cs_fall) begin
                  bit_cnt <= '0;
                  state   <= CMD;
               end
            end
            CMD: begin
               if (cs_rise) begin
                  FRAME_ERR <= 1'b1;
                  state     <= IDLE;
               end else if (sclk_rise) begin
                  rx_shift <= rx_byte[6:0];
                  if (bit_cnt == BYTE_LAST) begin
                     bit_cnt <= '0;
                     if (rx_byte == READ_CMD) begin
                        MISO     <= hold[DATA_BITS-1];
                        tx_shift <= hold[DATA_BITS-2:0];
                        state    <= READ;
                     end else begin
                        addr_q <= rx_byte;
                        state  <= WDATA;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            READ: begin
               if (cs_rise) begin
                  MISO  <= 1'b0;
                  state <= IDLE;
               end else if (sclk_rise) begin
                  tx_shift <= {tx_shift[DATA_BITS-3:0], 1'b0};
                  if (bit_cnt == WORD_LAST) begin
                     MISO  <= 1'b0;
                     state <= DRAIN;
                  end else begin
                     MISO    <= tx_shift[DATA_BITS-2];
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            WDATA: begin
               if (cs_rise) begin
                  FRAME_ERR <= 1'b1;
                  state     <= IDLE;
               end else if (sclk_rise) begin
                  rx_shift <= rx_byte[6:0];
                  if (bit_cnt == BYTE_LAST) begin
                     REG_ADDR <= addr_q;
                     REG_DATA <= rx_byte;
                     REG_WE   <= 1'b1;
                     state    <= DRAIN;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            DRAIN: begin
               MISO <= 1'b0;
               if (cs_rise) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_spi_slave.sv
// Bench for adc_spi_slave: a bit-banged SPI master plus a sample/register model of the emulated ADC,
// with directed frames followed by randomized reads, writes, sample pulses and aborted frames.
`timescale 1ns/1ps
module tb_adc_spi_slave;

   localparam logic [7:0] READ_CMD = 8'h1A;

   logic        CLK = 1'b0;
   logic        RST;
   logic [63:0] SAMPLE;
   logic        SAMPLE_VALID;
   logic        SCLK;
   logic        CS;
   logic        MOSI;
   logic        MISO;
   logic        EOC;
   logic [7:0]  REG_ADDR;
   logic [7:0]  REG_DATA;
   logic        REG_WE;
   logic        OVERRUN;
   logic        FRAME_ERR;

   adc_spi_slave #(.READ_CMD(READ_CMD), .DATA_BITS(64)) dut (
      .CLK(CLK), .RST(RST), .SAMPLE(SAMPLE), .SAMPLE_VALID(SAMPLE_VALID),
      .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO), .EOC(EOC),
      .REG_ADDR(REG_ADDR), .REG_DATA(REG_DATA), .REG_WE(REG_WE),
      .OVERRUN(OVERRUN), .FRAME_ERR(FRAME_ERR)
   );

   always #10 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Model of the emulated ADC: latest sample, unread flag, last register write, expected pulse counts.
   logic [63:0] m_hold = '0;
   bit          m_pending = 1'b0;
   logic [7:0]  m_addr = '0;
   logic [7:0]  m_data = '0;
   int          we_exp = 0, ovr_exp = 0, ferr_exp = 0;
   int          we_cnt = 0, ovr_cnt = 0, ferr_cnt = 0;
   bit          quiet = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_sample(input logic [63:0] v);
      if (m_pending) ovr_exp++;
      m_hold    = v;
      m_pending = 1'b1;
   endtask

   // Count cycles each strobe is high; a correct one-cycle pulse adds exactly one.
   always @(negedge CLK) begin
      if (REG_WE)    we_cnt   <= we_cnt + 1;
      if (OVERRUN)   ovr_cnt  <= ovr_cnt + 1;
      if (FRAME_ERR) ferr_cnt <= ferr_cnt + 1;
   end

   // Between transactions the outputs must match the model every cycle.
   always @(negedge CLK) begin
      if (quiet) begin
         check("idle_eoc", 64'(EOC), 64'(!m_pending));
         check("idle_miso", 64'(MISO), 64'd0);
         check("reg_addr", 64'(REG_ADDR), 64'(m_addr));
         check("reg_data", 64'(REG_DATA), 64'(m_data));
      end
   end

   task automatic check_counts();
      check("reg_we_pulses", 64'(we_cnt), 64'(we_exp));
      check("overrun_pulses", 64'(ovr_cnt), 64'(ovr_exp));
      check("frame_err_pulses", 64'(ferr_cnt), 64'(ferr_exp));
   endtask

   task automatic sample_pulse(input logic [63:0] v);
      quiet        = 1'b0;
      SAMPLE       = v;
      SAMPLE_VALID = 1'b1;
      model_sample(v);
      @(negedge CLK);
      SAMPLE_VALID = 1'b0;
      repeat (2) @(negedge CLK);
      quiet = 1'b1;
      check_counts();
   endtask

   // One SPI mode-0 frame, 4 CLK per SCLK phase. Optionally pulses SAMPLE_VALID two CLK after the
   // SCLK rise of edge inj_edge, or asserts reset while SCLK is high on edge rst_edge.
   task automatic spi_xfer(input int nbits, input logic [79:0] tx, input int inj_edge,
                           input logic [63:0] inj_val, input int rst_edge,
                           output logic [79:0] rx, output logic eoc_mid);
      rx      = '0;
      eoc_mid = 1'b1;
      quiet   = 1'b0;
      CS      = 1'b0;
      repeat (4) @(negedge CLK);
      for (int i = 0; i < nbits; i++) begin
         MOSI = tx[nbits-1-i];
         repeat (4) @(negedge CLK);
         SCLK = 1'b1;
         rx   = {rx[78:0], MISO};
         if (i == 12) eoc_mid = EOC;
         if (i == rst_edge) begin
            RST = 1'b0;
            #1;
            check("rst_miso", 64'(MISO), 64'd0);
            check("rst_eoc", 64'(EOC), 64'd1);
            m_hold = '0; m_pending = 1'b0; m_addr = '0; m_data = '0;
            SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0;
            repeat (2) @(negedge CLK);
            RST = 1'b1;
            repeat (4) @(negedge CLK);
            quiet = 1'b1;
            return;
         end
         for (int k = 0; k < 4; k++) begin
            if (i == inj_edge && k == 2) begin
               SAMPLE       = inj_val;
               SAMPLE_VALID = 1'b1;
               model_sample(inj_val);
            end else begin
               SAMPLE_VALID = 1'b0;
            end
            @(negedge CLK);
         end
         SAMPLE_VALID = 1'b0;
         SCLK         = 1'b0;
      end
      MOSI = 1'b0;
      repeat (4) @(negedge CLK);
      CS = 1'b1;
      repeat (6) @(negedge CLK);
      quiet = 1'b1;
   endtask

   task automatic do_read(input int inj_edge, input logic [63:0] inj_val, output logic [63:0] word);
      logic [79:0] rx;
      logic        mid;
      logic [63:0] exp;
      logic [63:0] junk;
      bit          exp_mid;
      exp       = m_hold;
      m_pending = 1'b0;
      exp_mid   = !(inj_edge >= 7 && inj_edge < 12);
      junk      = {$urandom, $urandom};
      spi_xfer(72, {8'h00, READ_CMD, junk}, inj_edge, inj_val, -1, rx, mid);
      word = rx[63:0];
      check("read_word", word, exp);
      check("eoc_after_cmd", 64'(mid), 64'(exp_mid));
      check_counts();
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      logic [79:0] rx;
      logic        mid;
      spi_xfer(16, {64'd0, a, d}, -1, 64'd0, -1, rx, mid);
      m_addr = a;
      m_data = d;
      we_exp++;
      check_counts();
   endtask

   // Send only the first n bits of an nfull-bit frame, then raise CS.
   task automatic do_abort(input logic [79:0] full, input int nfull, input int n);
      logic [79:0] rx;
      logic        mid;
      logic [7:0]  first;
      first = full[nfull-1 -: 8];
      spi_xfer(n, full >> (nfull - n), -1, 64'd0, -1, rx, mid);
      if (n >= 8 && first == READ_CMD) m_pending = 1'b0;
      else ferr_exp++;
      check_counts();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] w;
      logic [79:0] rx;
      logic        mid;
      logic [7:0]  a;
      logic [63:0] r;

      RST = 1'b0; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
      SAMPLE = '0; SAMPLE_VALID = 1'b0;
      repeat (3) @(negedge CLK);
      check("reset_miso", 64'(MISO), 64'd0);
      check("reset_eoc", 64'(EOC), 64'd1);
      check("reset_reg_addr", 64'(REG_ADDR), 64'd0);
      check("reset_reg_data", 64'(REG_DATA), 64'd0);
      check("reset_reg_we", 64'(REG_WE), 64'd0);
      check("reset_overrun", 64'(OVERRUN), 64'd0);
      check("reset_frame_err", 64'(FRAME_ERR), 64'd0);
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      quiet = 1'b1;

      // Basic read.
      sample_pulse(64'h1111_2222_3333_4444);
      check("eoc_low_after_sample", 64'(EOC), 64'd0);
      do_read(-1, 64'd0, w);
      check("lit_read_1", w, 64'h1111_2222_3333_4444);
      check("lit_eoc_after_read", 64'(EOC), 64'd1);

      // Register write.
      do_write(8'h05, 8'hA7);
      check("lit_reg_addr", 64'(REG_ADDR), 64'h05);
      check("lit_reg_data", 64'(REG_DATA), 64'hA7);
      check("lit_we_count", 64'(we_cnt), 64'd1);

      // Overrun: second sample overwrites the first.
      sample_pulse(64'hAAAA_AAAA_AAAA_AAAA);
      sample_pulse(64'h5555_5555_5555_5555);
      check("lit_overrun_count", 64'(ovr_cnt), 64'd1);
      do_read(-1, 64'd0, w);
      check("lit_read_after_overrun", w, 64'h5555_5555_5555_5555);

      // New sample during bit 20 of a read leaves the frame intact.
      sample_pulse(64'h0123_4567_89AB_CDEF);
      do_read(28, 64'hFFFF_0000_FFFF_0000, w);
      check("lit_read_coherent", w, 64'h0123_4567_89AB_CDEF);
      check("lit_eoc_low_after_frame", 64'(EOC), 64'd0);
      do_read(-1, 64'd0, w);
      check("lit_read_next", w, 64'hFFFF_0000_FFFF_0000);

      // Write frame aborted after 11 clocks, then a normal read.
      do_abort({64'd0, 8'h33, 8'h5C}, 16, 11);
      check("lit_frame_err_count", 64'(ferr_cnt), 64'd1);
      check("lit_we_after_abort", 64'(we_cnt), 64'd1);
      do_read(-1, 64'd0, w);
      check("lit_read_after_abort", w, 64'hFFFF_0000_FFFF_0000);

      // Sample arriving in the very cycle the read loads the shift register.
      sample_pulse(64'hDEAD_BEEF_0BAD_F00D);
      do_read(7, 64'hC0FF_EE00_1234_5678, w);
      check("lit_read_coincident", w, 64'hDEAD_BEEF_0BAD_F00D);
      check("lit_no_overrun_coincident", 64'(ovr_cnt), 64'd1);
      check("lit_eoc_coincident", 64'(EOC), 64'd0);
      do_read(-1, 64'd0, w);
      check("lit_read_after_coincident", w, 64'hC0FF_EE00_1234_5678);

      // Reset during bit 30 of a read.
      sample_pulse(64'h7777_8888_9999_AAAA);
      spi_xfer(72, {8'h00, READ_CMD, 64'd0}, -1, 64'd0, 38, rx, mid);
      check_counts();
      do_read(-1, 64'd0, w);
      check("lit_read_after_reset", w, 64'd0);
      check("lit_reg_addr_after_reset", 64'(REG_ADDR), 64'd0);

      // Randomized traffic.
      for (int t = 0; t < 30; t++) begin
         r = {$urandom, $urandom};
         a = 8'($urandom);
         if (a == READ_CMD) a = 8'h1B;
         case ($urandom_range(0, 5))
            0: sample_pulse(r);
            1: do_read(-1, 64'd0, w);
            2: do_read(int'($urandom_range(7, 70)), r, w);
            3: do_write(a, 8'($urandom));
            4: do_abort({64'd0, a, 8'($urandom)}, 16, int'($urandom_range(1, 15)));
            default: do_abort({8'h00, READ_CMD, r}, 72, int'($urandom_range(8, 71)));
         endcase
      end

      check_counts();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
